// File: rtl/iram_xtmemory_arb.sv
// -----------------------------------------------------------------------------
// iram_xtmemory_arb
//
// Local instruction RAM for the peregrine core. One single-ported array is
// shared by an instruction-fetch port (read-only) and a load/store port
// (read/write with byte-lane enables). Load/store wins arbitration, and the
// losing requester sees Busy and must hold its request. Reads return after
// RD_LAT cycles (1 or 2). An optional sequencer zero-fills the array after
// reset before any request is accepted.
//
// Ports:
//   CLK, Reset                  clock, asynchronous active-high reset
//   IFetchEn / IFetchAddr       fetch read request and word address
//   IFetchBusy                  fetch request not accepted this cycle
//   IFetchData / IFetchValid    fetch read return (data held while !Valid)
//   LSEn / LSWr / LSAddr        load/store request, 1 = write, word address
//   LSByteEn / LSWrData         write lane enables and write data
//   LSBusy                      load/store request not accepted this cycle
//   LSData / LSValid            load read return (data held while !Valid)
//   InitDone                    array is ready for use
// -----------------------------------------------------------------------------
module iram_xtmemory_arb #(
  parameter int WIDTH         = 32,
  parameter int NWORDS        = 131072,
  parameter int AWIDTH        = 17,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 IFetchEn,
  input  logic [AWIDTH-1:0]    IFetchAddr,
  output logic                 IFetchBusy,
  output logic [WIDTH-1:0]     IFetchData,
  output logic                 IFetchValid,
  input  logic                 LSEn,
  input  logic                 LSWr,
  input  logic [AWIDTH-1:0]    LSAddr,
  input  logic [WIDTH/8-1:0]   LSByteEn,
  input  logic [WIDTH-1:0]     LSWrData,
  output logic                 LSBusy,
  output logic [WIDTH-1:0]     LSData,
  output logic                 LSValid,
  output logic                 InitDone
);

  localparam int NLANES = WIDTH / 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam state_e            RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic              RESET_DONE  = (INIT_ON_RESET == 0);
  localparam logic [AWIDTH-1:0] LAST_WORD   = AWIDTH'(NWORDS - 1);
  localparam logic              PORT_IF     = 1'b0;
  localparam logic              PORT_LS     = 1'b1;

  // ---------------------------------------------------------------------------
  // Init / run sequencer
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [AWIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic              init_done_q, init_done_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      fill_cnt_d = fill_cnt_q + AWIDTH'(1);
      // The last word is written on this edge, so the array is ready after it.
      if (fill_cnt_q == LAST_WORD) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= RESET_STATE;
      fill_cnt_q  <= '0;
      init_done_q <= RESET_DONE;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign InitDone = init_done_q;

  // ---------------------------------------------------------------------------
  // Arbitration: load/store has priority, no retry queue
  // ---------------------------------------------------------------------------
  logic in_init;
  logic ls_acc;
  logic if_acc;

  assign in_init    = (state_q == ST_INIT);
  // Reset gates acceptance so nothing reaches the array while it is asserted.
  assign ls_acc     = !in_init && !Reset && LSEn;
  assign if_acc     = !in_init && !Reset && !LSEn && IFetchEn;
  assign LSBusy     = in_init;
  assign IFetchBusy = in_init || (!Reset && LSEn && IFetchEn);

  // ---------------------------------------------------------------------------
  // Array access (single port shared by fill, write and read)
  // ---------------------------------------------------------------------------
  logic              mem_we;
  logic [NLANES-1:0] mem_be;
  logic [WIDTH-1:0]  mem_wdata;
  logic [AWIDTH-1:0] mem_addr;
  logic              rd_en;
  logic              rd_port;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = LSWrData;
    mem_addr  = LSEn ? LSAddr : IFetchAddr;
    if (in_init) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_wdata = '0;
      mem_addr  = fill_cnt_q;
    end else if (ls_acc && LSWr) begin
      mem_we = 1'b1;
      mem_be = LSByteEn;
    end
  end

  assign rd_en   = (ls_acc && !LSWr) || if_acc;
  assign rd_port = ls_acc ? PORT_LS : PORT_IF;

  reg   [WIDTH-1:0] dataArray [0:NWORDS-1];
  logic [WIDTH-1:0] rd1_data_q;

  // NOTE: the array and its read register carry no reset; clearing storage is
  // the fill sequencer's job, and a reset here would prevent RAM inference.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NLANES; b++) begin
      if (mem_we && mem_be[b]) begin
        dataArray[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
    if (rd_en) begin
      rd1_data_q <= dataArray[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Read return pipeline: stage 1 tags the read with its owning port
  // ---------------------------------------------------------------------------
  logic rd1_valid_q, rd1_valid_d;
  logic rd1_port_q, rd1_port_d;

  assign rd1_valid_d = rd_en;
  assign rd1_port_d  = rd_port;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd1_valid_q <= 1'b0;
      rd1_port_q  <= PORT_IF;
    end else begin
      rd1_valid_q <= rd1_valid_d;
      rd1_port_q  <= rd1_port_d;
    end
  end

  logic             fin_valid;
  logic             fin_port;
  logic [WIDTH-1:0] fin_data;

  if (RD_LAT == 2) begin : g_lat2
    logic             rd2_valid_q;
    logic             rd2_port_q;
    logic [WIDTH-1:0] rd2_data_q;

    always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
        rd2_valid_q <= 1'b0;
        rd2_port_q  <= PORT_IF;
        rd2_data_q  <= '0;
      end else begin
        rd2_valid_q <= rd1_valid_q;
        rd2_port_q  <= rd1_port_q;
        rd2_data_q  <= rd1_data_q;
      end
    end

    assign fin_valid = rd2_valid_q;
    assign fin_port  = rd2_port_q;
    assign fin_data  = rd2_data_q;
  end else begin : g_lat1
    assign fin_valid = rd1_valid_q;
    assign fin_port  = rd1_port_q;
    assign fin_data  = rd1_data_q;
  end

  // ---------------------------------------------------------------------------
  // Per-port outputs; each port keeps its last returned word while idle
  // ---------------------------------------------------------------------------
  logic             if_valid, ls_valid;
  logic [WIDTH-1:0] if_hold_q, if_hold_d;
  logic [WIDTH-1:0] ls_hold_q, ls_hold_d;

  assign if_valid  = fin_valid && (fin_port == PORT_IF);
  assign ls_valid  = fin_valid && (fin_port == PORT_LS);
  assign if_hold_d = if_valid ? fin_data : if_hold_q;
  assign ls_hold_d = ls_valid ? fin_data : ls_hold_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      if_hold_q <= '0;
      ls_hold_q <= '0;
    end else begin
      if_hold_q <= if_hold_d;
      ls_hold_q <= ls_hold_d;
    end
  end

  assign IFetchValid = if_valid;
  assign LSValid     = ls_valid;
  assign IFetchData  = if_valid ? fin_data : if_hold_q;
  assign LSData      = ls_valid ? fin_data : ls_hold_q;

endmodule

// File: tb/tb_iram_xtmemory_arb.sv
// -----------------------------------------------------------------------------
// tb_iram_xtmemory_arb
//
// Directed bench for iram_xtmemory_arb. Two instances share one clock:
//   dut_a : WIDTH=32,  NWORDS=16, RD_LAT=1, INIT_ON_RESET=1
//   dut_b : WIDTH=128, NWORDS=16, RD_LAT=2, INIT_ON_RESET=1
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_iram_xtmemory_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // ---------------- dut_a signals ----------------
  logic        rst_a;
  logic        a_if_en, a_if_busy, a_if_valid;
  logic [3:0]  a_if_addr;
  logic [31:0] a_if_data;
  logic        a_ls_en, a_ls_wr, a_ls_busy, a_ls_valid;
  logic [3:0]  a_ls_addr, a_ls_be;
  logic [31:0] a_ls_wdata, a_ls_data;
  logic        a_done;

  // ---------------- dut_b signals ----------------
  logic         rst_b;
  logic         b_if_en, b_if_busy, b_if_valid;
  logic [3:0]   b_if_addr;
  logic [127:0] b_if_data;
  logic         b_ls_en, b_ls_wr, b_ls_busy, b_ls_valid;
  logic [3:0]   b_ls_addr;
  logic [15:0]  b_ls_be;
  logic [127:0] b_ls_wdata, b_ls_data;
  logic         b_done;

  iram_xtmemory_arb #(
    .WIDTH(32), .NWORDS(16), .AWIDTH(4), .RD_LAT(1), .INIT_ON_RESET(1)
  ) dut_a (
    .CLK(clk), .Reset(rst_a),
    .IFetchEn(a_if_en), .IFetchAddr(a_if_addr), .IFetchBusy(a_if_busy),
    .IFetchData(a_if_data), .IFetchValid(a_if_valid),
    .LSEn(a_ls_en), .LSWr(a_ls_wr), .LSAddr(a_ls_addr), .LSByteEn(a_ls_be),
    .LSWrData(a_ls_wdata), .LSBusy(a_ls_busy), .LSData(a_ls_data),
    .LSValid(a_ls_valid), .InitDone(a_done)
  );

  iram_xtmemory_arb #(
    .WIDTH(128), .NWORDS(16), .AWIDTH(4), .RD_LAT(2), .INIT_ON_RESET(1)
  ) dut_b (
    .CLK(clk), .Reset(rst_b),
    .IFetchEn(b_if_en), .IFetchAddr(b_if_addr), .IFetchBusy(b_if_busy),
    .IFetchData(b_if_data), .IFetchValid(b_if_valid),
    .LSEn(b_ls_en), .LSWr(b_ls_wr), .LSAddr(b_ls_addr), .LSByteEn(b_ls_be),
    .LSWrData(b_ls_wdata), .LSBusy(b_ls_busy), .LSData(b_ls_data),
    .LSValid(b_ls_valid), .InitDone(b_done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] bd [4];

  initial begin
    bd[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bd[1] = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    bd[2] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bd[3] = 128'hCAFE_F00D_BEEF_0001_DEAD_0002_FACE_0003;

    rst_a = 1'b1; rst_b = 1'b1;
    a_if_en = 0; a_if_addr = '0; a_ls_en = 0; a_ls_wr = 0; a_ls_addr = '0;
    a_ls_be = '0; a_ls_wdata = '0;
    b_if_en = 0; b_if_addr = '0; b_ls_en = 0; b_ls_wr = 0; b_ls_addr = '0;
    b_ls_be = '0; b_ls_wdata = '0;

    // ---------------- reset state ----------------
    #1;
    check("a_rst_busy_done", {a_if_busy, a_ls_busy, a_done}, 3'b110);
    check("a_rst_valids", {a_if_valid, a_ls_valid}, 2'b00);
    check("a_rst_if_data", a_if_data, 32'h0);
    check("a_rst_ls_data", a_ls_data, 32'h0);
    tick; tick;
    rst_a = 1'b0; rst_b = 1'b0;

    // ---------------- zero-fill: busy exactly 16 cycles ----------------
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("a_fill_busy_%0d", i), {a_if_busy, a_ls_busy, a_done}, 3'b110);
      tick;
    end
    check("a_fill_done", {a_if_busy, a_ls_busy, a_done}, 3'b001);
    check("b_fill_done", {b_if_busy, b_ls_busy, b_done}, 3'b001);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a_peek_zero_%0d", i), dut_a.dataArray[i], 32'h0);
    end

    // ---------------- full write then read back ----------------
    a_ls_en = 1; a_ls_wr = 1; a_ls_addr = 4'd5; a_ls_be = 4'hF; a_ls_wdata = 32'hDEADBEEF;
    #1;
    check("a_wr_ls_busy", a_ls_busy, 1'b0);
    tick;
    a_ls_wr = 0;
    check("a_wr_no_valid", a_ls_valid, 1'b0);
    tick;
    check("a_rd5_valid", a_ls_valid, 1'b1);
    check("a_rd5_data", a_ls_data, 32'hDEADBEEF);
    check("a_rd5_if_quiet", a_if_valid, 1'b0);
    a_ls_en = 0;
    tick;
    check("a_rd5_valid_drop", a_ls_valid, 1'b0);
    check("a_rd5_data_hold", a_ls_data, 32'hDEADBEEF);

    // ---------------- byte lanes, then a zero-enable write ----------------
    a_ls_en = 1; a_ls_wr = 1; a_ls_addr = 4'd7; a_ls_be = 4'hF; a_ls_wdata = 32'h11223344;
    tick;
    a_ls_be = 4'b0101; a_ls_wdata = 32'hAABBCCDD;
    tick;
    a_ls_be = 4'b0000; a_ls_wdata = 32'hFFFFFFFF;
    tick;
    a_ls_wr = 0;
    tick;
    check("a_lane_valid", a_ls_valid, 1'b1);
    check("a_lane_data", a_ls_data, 32'h11BB33DD);

    // ---------------- contention: load/store keeps reading word 7 ----------------
    a_if_en = 1; a_if_addr = 4'd5;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("a_cont_if_busy_%0d", k), a_if_busy, 1'b1);
      check($sformatf("a_cont_ls_busy_%0d", k), a_ls_busy, 1'b0);
      tick;
      check($sformatf("a_cont_ls_valid_%0d", k), {a_ls_valid, a_ls_data}, {1'b1, 32'h11BB33DD});
      check($sformatf("a_cont_if_quiet_%0d", k), a_if_valid, 1'b0);
    end
    a_ls_en = 0;
    #1;
    check("a_cont_if_free", a_if_busy, 1'b0);
    tick;
    check("a_fetch_valid", a_if_valid, 1'b1);
    check("a_fetch_data", a_if_data, 32'hDEADBEEF);
    check("a_fetch_ls_quiet", a_ls_valid, 1'b0);
    check("a_fetch_ls_hold", a_ls_data, 32'h11BB33DD);
    a_if_en = 0;
    tick;
    check("a_fetch_valid_drop", a_if_valid, 1'b0);
    check("a_fetch_data_hold", a_if_data, 32'hDEADBEEF);

    // ---------------- dut_b: preload words 8..11 ----------------
    b_ls_en = 1; b_ls_wr = 1; b_ls_be = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      b_ls_addr = 4'(8 + i); b_ls_wdata = bd[i];
      tick;
    end
    b_ls_wr = 0;

    // ---------------- alternating reads, RD_LAT=2 ----------------
    b_ls_en = 0; b_if_en = 1; b_if_addr = 4'd8;
    #1;
    check("b_alt_if_busy", b_if_busy, 1'b0);
    tick;
    check("b_alt1_none", {b_if_valid, b_ls_valid}, 2'b00);
    b_if_en = 0; b_ls_en = 1; b_ls_addr = 4'd9;
    tick;
    check("b_alt2_valids", {b_if_valid, b_ls_valid}, 2'b10);
    check("b_alt2_if_data", b_if_data, bd[0]);
    b_ls_en = 0; b_if_en = 1; b_if_addr = 4'd10;
    tick;
    check("b_alt3_valids", {b_if_valid, b_ls_valid}, 2'b01);
    check("b_alt3_ls_data", b_ls_data, bd[1]);
    b_if_en = 0; b_ls_en = 1; b_ls_addr = 4'd11;
    tick;
    check("b_alt4_valids", {b_if_valid, b_ls_valid}, 2'b10);
    check("b_alt4_if_data", b_if_data, bd[2]);
    check("b_alt4_ls_hold", b_ls_data, bd[1]);
    b_ls_en = 0;
    tick;
    check("b_alt5_valids", {b_if_valid, b_ls_valid}, 2'b01);
    check("b_alt5_ls_data", b_ls_data, bd[3]);
    check("b_alt5_if_hold", b_if_data, bd[2]);
    tick;
    check("b_alt6_valids", {b_if_valid, b_ls_valid}, 2'b00);

    // ---------------- reset with reads in flight ----------------
    b_ls_en = 1; b_ls_wr = 1; b_ls_addr = 4'd0; b_ls_wdata = bd[3];
    tick;
    b_ls_addr = 4'd15; b_ls_wdata = bd[1];
    tick;
    b_ls_wr = 0; b_ls_en = 0; b_if_en = 1; b_if_addr = 4'd8;
    tick;
    b_if_en = 0; b_ls_en = 1; b_ls_addr = 4'd9;
    tick;
    check("b_pre_rst_if_valid", b_if_valid, 1'b1);
    b_if_en = 1;
    rst_b = 1'b1;
    #1;
    check("b_rst_valids", {b_if_valid, b_ls_valid}, 2'b00);
    check("b_rst_data", {b_if_data, b_ls_data}, 256'h0);
    check("b_rst_busy_done", {b_if_busy, b_ls_busy, b_done}, 3'b110);
    for (int k = 0; k < 2; k++) begin
      tick;
      check($sformatf("b_rst_quiet_%0d", k), {b_if_valid, b_ls_valid}, 2'b00);
    end
    rst_b = 1'b0; b_if_en = 0; b_ls_en = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check($sformatf("b_refill_busy_%0d", i), {b_if_busy, b_ls_busy, b_done, b_if_valid, b_ls_valid}, 5'b11000);
      tick;
      if (i == 0) begin
        check("b_refill_word0_first", dut_b.dataArray[0], 128'h0);
        check("b_refill_word15_later", dut_b.dataArray[15], bd[1]);
      end
    end
    check("b_refill_done", {b_if_busy, b_ls_busy, b_done}, 3'b001);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_peek_zero_%0d", i), dut_b.dataArray[i], 128'h0);
    end
    check("a_unaffected_done", a_done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
